// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types and constants for the two-requester data-memory
//               port arbiter (requester IDs, in-flight tag, default widths).
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    localparam int DEF_ADDR_W = 10;
    localparam int DEF_DATA_W = 32;

    // Requester identifiers; also the bit index into the 2-bit request vectors.
    localparam logic REQ_FETCH = 1'b0;
    localparam logic REQ_LS    = 1'b1;

    // One in-flight memory access waiting for its response slot.
    typedef struct packed {
        logic valid;
        logic id;
        logic is_write;
    } tag_t;

    // Drops a fetch entry when the fetch stream is being redirected.
    function automatic tag_t squash_fetch(input tag_t t, input logic flush);
        tag_t r;
        r = t;
        if (flush && (t.id == REQ_FETCH)) begin
            r.valid = 1'b0;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter2
// Description : Two-input round-robin arbiter. Grants at most one valid
//               requester per cycle; priority flips to the other requester
//               after every accepted grant.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] valid_i,
    output logic [1:0] grant_o
);

    // Requester that currently holds priority.
    logic ptr_q;
    logic ptr_d;
    logic other;

    assign other = ~ptr_q;

    // Grant the priority holder if it asks, otherwise the other one; nothing in reset.
    always_comb begin
        grant_o = 2'b00;
        ptr_d   = ptr_q;
        if (!reset) begin
            if (valid_i[ptr_q]) begin
                grant_o[ptr_q] = 1'b1;
            end else if (valid_i[other]) begin
                grant_o[other] = 1'b1;
            end
        end
        // A grant is always an accept, because ready is only raised alongside valid.
        if (grant_o[0]) begin
            ptr_d = 1'b1;
        end else if (grant_o[1]) begin
            ptr_d = 1'b0;
        end
    end

    // Priority pointer register; fetch has priority out of reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one pipelined single-port word memory between fetch
//               and load/store. Round-robin grant, fixed-latency responses
//               routed back through a tag shift pipeline, fetch flush.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int MEM_LATENCY = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic [1:0]          req_we,
    input  logic [2*ADDR_W-1:0] req_addr,
    input  logic [2*DATA_W-1:0] req_wdata,
    output logic [1:0]          rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    input  logic                flush_fetch,
    output logic                mem_en,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata
);

    logic [1:0] grant;
    logic       sel;
    tag_t       tags_q [MEM_LATENCY];
    tag_t       tags_d [MEM_LATENCY];
    tag_t       head;
    logic       rsp_live;

    rr_arbiter2 u_arb (
        .clk     (clk),
        .reset   (reset),
        .valid_i (req_valid),
        .grant_o (grant)
    );

    assign req_ready = grant;
    assign sel       = grant[REQ_LS];

    // Steer the granted requester onto the memory port; drive zeros when idle.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (grant != 2'b00) begin
            mem_en    = 1'b1;
            mem_we    = req_we[sel];
            mem_addr  = sel ? req_addr[ADDR_W +: ADDR_W]  : req_addr[0 +: ADDR_W];
            mem_wdata = sel ? req_wdata[DATA_W +: DATA_W] : req_wdata[0 +: DATA_W];
        end
    end

    // Shift the tag pipeline one slot per cycle; a flush kills every fetch
    // entry, including the one being accepted right now.
    always_comb begin
        tags_d[0] = squash_fetch(tag_t'{valid: mem_en, id: sel, is_write: mem_we},
                                 flush_fetch);
        for (int i = 1; i < MEM_LATENCY; i++) begin
            tags_d[i] = squash_fetch(tags_q[i-1], flush_fetch);
        end
    end

    // Tag pipeline registers; reset drops everything still in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < MEM_LATENCY; i++) begin
                tags_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < MEM_LATENCY; i++) begin
                tags_q[i] <= tags_d[i];
            end
        end
    end

    // The oldest entry is due this cycle; a flush also kills a fetch response
    // landing in the same cycle.
    assign head     = squash_fetch(tags_q[MEM_LATENCY-1], flush_fetch);
    assign rsp_live = head.valid && !reset;

    assign rsp_valid = rsp_live ? (2'b01 << head.id) : 2'b00;
    assign rsp_rdata = (rsp_live && !head.is_write) ? mem_rdata : '0;

endmodule
`default_nettype wire
